// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
// Holds the controller state encoding and the default reset vector / alignment.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VEC   = 32'h0000_0000;
    localparam int          DEFAULT_IALIGN_BITS = 2;

endpackage

// File: rtl/pc_gen.sv
// RV32I fetch program-counter generator: advances under a valid/ready handshake,
// accepts trap/branch redirects and parks in FAULT on a misaligned branch target.
module pc_gen
    import pc_pkg::*;
#(
    parameter int                 XLEN        = 32,
    parameter logic [XLEN-1:0]    RESET_VEC   = XLEN'(DEFAULT_RESET_VEC),
    parameter int                 IALIGN_BITS = DEFAULT_IALIGN_BITS
) (
    input  logic            clk_pc,
    input  logic            rst_pc_n,
    input  logic            fetch_ready,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] INC       = XLEN'(1) << IALIGN_BITS;
    localparam logic [XLEN-1:0] LOW_MASK  = INC - XLEN'(1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] trapAligned;
    logic            redirMisaligned;

    assign pc_plus_inc     = pc_q + INC;
    assign trapAligned     = trap_target & ~LOW_MASK;
    assign redirMisaligned = |(redir_target & LOW_MASK);

    always_ff @(posedge clk_pc or negedge rst_pc_n) begin
        if (!rst_pc_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Trap beats redirect beats advance; a redirect drops any un-accepted address.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
                err_d   = 1'b0;
            end
            RUN: begin
                if (trap_valid) begin
                    pc_d = trapAligned;
                end else if (redir_valid) begin
                    if (redirMisaligned) begin
                        state_d = FAULT;
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        pc_d = redir_target;
                    end
                end else if (valid_q && fetch_ready) begin
                    pc_d = pc_plus_inc;
                end
            end
            FAULT: begin
                valid_d = 1'b0;
                if (trap_valid) begin
                    state_d = RUN;
                    pc_d    = trapAligned;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    assign pc_out       = pc_q;
    assign pc_valid     = valid_q;
    assign misalign_err = err_q;

endmodule
